fnn_layer_ctrl: RTL and testbench

//  Sequencer for one fully connected layer of NUM_NEURON neuron instances that share one input bus.
//  - Accepts one sample (NUM_WEIGHT words) on a valid/ready stream and broadcasts each word to all neurons.
//  - Collects each neuron's result on its outvalid pulse, then streams the NUM_NEURON results to the next layer.

---
 rtl/fnn_layer_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fnn_layer_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnn_layer_ctrl.sv
// fnn_layer_ctrl: sequencer for one fully connected layer.
// One input sample of NUM_WEIGHT words comes in on a valid/ready stream, and every
// word is broadcast to all neurons. The block then collects each neuron's result on
// its outvalid pulse and streams the NUM_NEURON results out in bank order.
//
// Optional feature: define FNN_LAYER_CTRL_ARGMAX_EN to add argmax_idx/argmax_valid.
// These report the index of the largest signed result in each drained sample.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_data/in_valid/in_ready   input word stream from the previous layer
//   nrn_data/nrn_valid          one-cycle broadcast of each accepted word to the neurons
//   nrn_out/nrn_outvalid        neuron results; neuron i sits at [i*DATA_WIDTH+:DATA_WIDTH]
//   out_data/out_valid/out_ready/out_last   result stream to the next layer
//   busy                     high whenever the sequencer is not idle
//   err                      sticky flag: some neuron failed to report before TIMEOUT
//   argmax_idx/argmax_valid  (ARGMAX_EN only) winner index and a one-cycle pulse

// One result slot: latches the first outvalid of its neuron, ignores any repeats.
module fnn_cap_slot #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  cap,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hit <= 1'b0;
            q   <= '0;
        end else if (cap && !hit) begin
            hit <= 1'b1;
            q   <= din;
        end
    end
endmodule

module fnn_layer_ctrl #(
    parameter int NUM_WEIGHT = 30,
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            nrn_data,
    output logic                             nrn_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] nrn_out,
    input  logic [NUM_NEURON-1:0]            nrn_outvalid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
`ifdef FNN_LAYER_CTRL_ARGMAX_EN
    output logic [$clog2(NUM_NEURON)-1:0]    argmax_idx,
    output logic                             argmax_valid,
`endif
    output logic                             err
);
    localparam int CW = $clog2(NUM_WEIGHT + 1);
    localparam int OW = $clog2(NUM_NEURON + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] in_cnt;
    logic [OW-1:0] out_idx;
    logic [WW-1:0] wait_cnt;
    logic [NUM_NEURON-1:0]                 cap_mask;
    logic [NUM_NEURON-1:0][DATA_WIDTH-1:0] bank;

    logic in_xfer, out_xfer, last_word, all_cap, timeout, drain_done;

    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;
    // In IDLE in_cnt is 0, so NUM_WEIGHT==1 also makes the first word the last one.
    assign last_word  = (in_cnt == CW'(NUM_WEIGHT - 1));
    // Count this cycle's pulses too, so completion is seen in the capture cycle.
    assign all_cap    = &(cap_mask | nrn_outvalid);
    assign timeout    = (wait_cnt == WW'(TIMEOUT - 1));
    assign drain_done = out_xfer & out_last;

    assign busy      = (state != IDLE);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (out_idx == OW'(NUM_NEURON - 1));

    genvar g;
    generate
        for (g = 0; g < NUM_NEURON; g++) begin : g_slot
            fnn_cap_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
                .clk (clk),
                .rst (rst),
                .clr (drain_done),
                .cap ((state == WAIT) && nrn_outvalid[g]),
                .din (nrn_out[g*DATA_WIDTH +: DATA_WIDTH]),
                .hit (cap_mask[g]),
                .q   (bank[g])
            );
        end
    endgenerate

    // Index mux written as a compare loop so out_idx need not match the bank range.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_NEURON; i++)
            if (out_idx == OW'(i)) out_data = bank[i];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FEED: if (in_xfer) state_nxt = last_word ? WAIT : FEED;
            WAIT:       if (all_cap || timeout) state_nxt = DRAIN;
            DRAIN:      if (drain_done) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            nrn_valid <= 1'b0;
            nrn_data  <= '0;
            in_cnt    <= '0;
            wait_cnt  <= '0;
            out_idx   <= '0;
            err       <= 1'b0;
        end else begin
            // Registered ready: it drops the cycle after the last word is taken.
            in_ready  <= (state_nxt == IDLE) || (state_nxt == FEED);
            nrn_valid <= in_xfer;
            if (in_xfer) begin
                nrn_data <= in_data;
                in_cnt   <= last_word ? '0 : in_cnt + CW'(1);
            end
            wait_cnt <= (state == WAIT) ? wait_cnt + WW'(1) : '0;
            if (state == WAIT && !all_cap && timeout) err <= 1'b1;
            if (drain_done)    out_idx <= '0;
            else if (out_xfer) out_idx <= out_idx + OW'(1);
        end
    end

`ifdef FNN_LAYER_CTRL_ARGMAX_EN
    localparam int AW = $clog2(NUM_NEURON);
    logic [DATA_WIDTH-1:0] run_max;
    logic [AW-1:0]         run_idx;
    logic                  take;

    // Strict greater-than keeps the lower index on ties.
    assign take = (out_idx == '0) || ($signed(out_data) > $signed(run_max));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max      <= '0;
            run_idx      <= '0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
        end else begin
            argmax_valid <= drain_done;
            if (out_xfer && take) begin
                run_max <= out_data;
                run_idx <= AW'(out_idx);
            end
            if (drain_done) argmax_idx <= take ? AW'(out_idx) : run_idx;
        end
    end
`endif
endmodule

// File: tb/tb_fnn_layer_ctrl.sv
module tb_fnn_layer_ctrl;
    localparam int NW = 4, NN = 3, DW = 16, TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] in_data, nrn_data, out_data;
    logic in_valid, in_ready, nrn_valid, out_valid, out_ready, out_last, busy, err;
    logic [NN*DW-1:0] nrn_out;
    logic [NN-1:0] nrn_outvalid;
`ifdef FNN_LAYER_CTRL_ARGMAX_EN
    logic [1:0] argmax_idx;
    logic argmax_valid;
`endif

    fnn_layer_ctrl #(.NUM_WEIGHT(NW), .NUM_NEURON(NN), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .nrn_data(nrn_data), .nrn_valid(nrn_valid),
        .nrn_out(nrn_out), .nrn_outvalid(nrn_outvalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy),
`ifdef FNN_LAYER_CTRL_ARGMAX_EN
        .argmax_idx(argmax_idx), .argmax_valid(argmax_valid),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction level) ----------------
    bit            m_rdy, m_nv, m_xfer, m_wait, m_drain, m_err, m_amv;
    logic [DW-1:0] m_nd;
    int            m_taken, m_waited, m_amidx, m_amidx_pend;
    bit            got[NN];
    logic [DW-1:0] res[NN];
    logic [DW-1:0] dq[$];
    logic [DW-1:0] obs_q[$];

    function automatic int argmax_of();
        int best = 0;
        for (int i = 1; i < NN; i++)
            if ($signed(res[i]) > $signed(res[best])) best = i;
        return best;
    endfunction

    task automatic start_drain();
        dq.delete();
        for (int i = 0; i < NN; i++) dq.push_back(res[i]);
        m_amidx_pend = argmax_of();
        m_wait  = 0;
        m_drain = 1;
    endtask

    task automatic clear_sample();
        m_taken = 0;
        for (int i = 0; i < NN; i++) begin got[i] = 0; res[i] = '0; end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_rdy = 0; m_nv = 0; m_nd = '0; m_xfer = 0; m_wait = 0; m_drain = 0;
            m_err = 0; m_amv = 0; m_amidx = 0; m_waited = 0;
            dq.delete();
            clear_sample();
        end else begin
            m_xfer = in_valid && m_rdy;
            m_nv   = m_xfer;
            if (m_xfer) m_nd = in_data;
            m_amv = 0;
            if (m_drain) begin
                if (out_ready) begin
                    void'(dq.pop_front());
                    if (dq.size() == 0) begin
                        m_drain = 0;
                        m_amv   = 1;
                        m_amidx = m_amidx_pend;
                        clear_sample();
                    end
                end
            end else if (m_wait) begin
                bit all;
                all = 1;
                for (int i = 0; i < NN; i++) begin
                    if (nrn_outvalid[i] && !got[i]) begin got[i] = 1; res[i] = nrn_out[i*DW +: DW]; end
                    if (!got[i]) all = 0;
                end
                if (all) start_drain();
                else if (m_waited == TO - 1) begin m_err = 1; start_drain(); end
                m_waited++;
            end else if (m_xfer) begin
                m_taken++;
                if (m_taken == NW) begin m_wait = 1; m_waited = 0; end
            end
            m_rdy = !m_wait && !m_drain;
        end
    end

    // Observed output transfers, for literal per-test checks.
    always @(posedge clk)
        if (!rst && out_valid && out_ready) obs_q.push_back(out_data);

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  in_ready,  m_rdy);
            check("nrn_valid", nrn_valid, m_nv);
            check("nrn_data",  nrn_data,  m_nd);
            check("busy",      busy,      (m_taken > 0) || m_wait || m_drain);
            check("err",       err,       m_err);
            check("out_valid", out_valid, m_drain);
            if (m_drain) begin
                check("out_data", out_data, dq[0]);
                check("out_last", out_last, dq.size() == 1);
            end else
                check("out_last_idle", out_last, 0);
`ifdef FNN_LAYER_CTRL_ARGMAX_EN
            check("argmax_valid", argmax_valid, m_amv);
            check("argmax_idx",   argmax_idx,   m_amidx);
`endif
        end
    end

    // ---------------- stimulus helpers (all enter and leave on a negedge) ----------------
    task automatic send(input logic [DW-1:0] d);
        bit done = 0;
        in_data  = d;
        in_valid = 1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (m_xfer) done = 1;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_sample(input logic [DW-1:0] base);
        for (int w = 0; w < NW; w++) send(base + DW'(w));
        in_valid = 0;
    endtask

    task automatic fire(input logic [NN-1:0] mask, input logic [DW-1:0] v0, v1, v2);
        nrn_out      = {v2, v1, v0};
        nrn_outvalid = mask;
        @(negedge clk);
        nrn_outvalid = '0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!m_drain && !m_wait && m_taken == 0) done = 1;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic check_obs(input string name, input logic [DW-1:0] e0, e1, e2);
        check({name, "_cnt"}, obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check({name, "_w0"}, obs_q[0], e0);
            check({name, "_w1"}, obs_q[1], e1);
            check({name, "_w2"}, obs_q[2], e2);
        end
        obs_q.delete();
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0; nrn_out = '0; nrn_outvalid = '0; out_ready = 1;
        @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        check("rst_in_ready",  in_ready,  0);
        check("rst_busy",      busy,      0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        rst = 0;
        @(negedge clk);

        // 1: reset in the middle of FEED aborts the sample
        send(16'h0051); send(16'h0052); in_valid = 0;
        check("feed_busy", busy, 1);
        rst = 1;
        repeat (2) @(negedge clk);
        check("midrst_busy",     busy,      0);
        check("midrst_nrn_data", nrn_data,  0);
        check("midrst_in_ready", in_ready,  0);
        rst = 0;
        @(negedge clk);
        obs_q.delete();

        // 2: nominal sample, all neurons report together
        send_sample(16'd1);
        check("t2_in_ready_drop", in_ready, 0);
        check("t2_last_word",     nrn_data, 4);
        fire(3'b111, 16'd10, 16'd20, 16'd30);
        wait_idle();
        check_obs("t2", 16'd10, 16'd20, 16'd30);

        // 3: staggered reports, with a repeated pulse from neuron 2
        send_sample(16'h0100);
        @(negedge clk);
        fire(3'b100, 16'h0, 16'h0, 16'h0033);
        @(negedge clk);
        fire(3'b001, 16'h0011, 16'h0, 16'h0);
        fire(3'b100, 16'h0, 16'h0, 16'h0099);
        check("t3_still_wait", out_valid, 0);
        fire(3'b010, 16'h0, 16'h0022, 16'h0);
        check("t3_drain", out_valid, 1);
        wait_idle();
        check_obs("t3", 16'h0011, 16'h0022, 16'h0033);

        // 4: backpressure on word 0, input held valid during DRAIN
        send_sample(16'h0200);
        out_ready = 0;
        in_valid = 1; in_data = 16'hAAAA;
        fire(3'b111, 16'd5, 16'd6, 16'd7);
        repeat (5) @(negedge clk);
        check("t4_hold_data", out_data, 5);
        check("t4_no_accept", in_ready, 0);
        out_ready = 1;
        wait_idle();
        in_valid = 0;
        check_obs("t4", 16'd5, 16'd6, 16'd7);

        // 5: neuron 1 never reports -> timeout, zero in its slot, sticky err
        send_sample(16'h0300);
        fire(3'b101, 16'h000A, 16'h0, 16'h000C);
        wait_idle();
        check("t5_err", err, 1);
        check_obs("t5", 16'h000A, 16'h0000, 16'h000C);
        send_sample(16'h0400);
        fire(3'b111, 16'd1, 16'd2, 16'd3);
        wait_idle();
        check("t5_err_sticky", err, 1);
        check_obs("t5b", 16'd1, 16'd2, 16'd3);

`ifdef FNN_LAYER_CTRL_ARGMAX_EN
        // 6: signed argmax with a tie -> lower index wins
        send_sample(16'h0500);
        fire(3'b111, 16'h0100, 16'hFF00, 16'h0100);
        wait_idle();
        check("t6_am_valid", argmax_valid, 1);
        check("t6_am_idx",   argmax_idx,   0);
        @(negedge clk);
        check("t6_am_pulse", argmax_valid, 0);
        obs_q.delete();
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
